// File: rtl/mvm_stream_pkg.sv
// Shared types and sizing helpers for the streaming matrix-vector multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mvm_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    COMPUTE,
    FLUSH,
    EMIT
  } state_t;

  // Pipeline lead between column address and accumulate (read reg + multiply reg).
  localparam int PIPE_DEPTH = 2;

  // Full-precision accumulator width: one B x B product plus growth for K terms.
  function automatic int acc_width(input int b, input int k);
    return 2 * b + $clog2(k);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_stream_lane.sv
// One MAC lane: local slice of A, multiply register, clearable accumulator, result register.
// Latency: read reg -> multiply reg -> accumulate; result latched on the final accumulate cycle.
// Backpressure: none; the top-level sequencer only advances the lane when the stream allows.
// Ports: wr_en/addr/wr_data write A; addr also drives the synchronous read; x_val is the
//        aligned x element; acc_clr/acc_en/latch come from the top-level FSM; result is
//        this lane's y entry for the current pass.
module mvm_lane #(
  parameter int B       = 16,
  parameter int ACC_W   = 35,
  parameter int A_DEPTH = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           addr,
  input  logic signed [B-1:0]     wr_data,
  input  logic signed [B-1:0]     x_val,
  input  logic                    acc_clr,
  input  logic                    acc_en,
  input  logic                    latch,
  output logic signed [ACC_W-1:0] result
);

  logic signed [B-1:0]     mem [A_DEPTH];
  logic signed [B-1:0]     a_q;
  logic signed [2*B-1:0]   prod_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;

  // Matrix storage is intentionally not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    a_q <= mem[addr];
  end

  assign prod_ext = {{(ACC_W-2*B){prod_q[2*B-1]}}, prod_q};
  assign acc_sum  = acc_q + prod_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      acc_q  <= '0;
      result <= '0;
    end else begin
      prod_q <= a_q * x_val;
      if (acc_clr)     acc_q <= '0;
      else if (acc_en) acc_q <= acc_sum;
      // The final product is still in flight when the sequencer latches, so take the sum.
      if (latch) result <= acc_sum;
    end
  end

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x with P parallel MAC lanes; A and x loaded over one valid/ready input.
// Latency: K+2 cycles per pass from pass entry to result latch, then P output beats.
// Backpressure: in_ready only in load states; out_valid holds data until out_ready.
// Ports: load_matrix/load_vector/start command pulses (IDLE only); in_* load stream;
//        out_* result stream with out_last on y[M-1]; busy while not IDLE; done pulse.
module mvm_stream
  import mvm_stream_pkg::*;
#(
  parameter int K     = 8,
  parameter int M     = 8,
  parameter int P     = 2,
  parameter int B     = 16,
  parameter int ACC_W = acc_width(B, K)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_matrix,
  input  logic                    load_vector,
  input  logic                    start,
  input  logic signed [B-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int ROWS_PER_LANE = M / P;
  localparam int A_DEPTH       = ROWS_PER_LANE * K;
  localparam int AW            = idx_width(A_DEPTH);
  localparam int CW            = idx_width(K);
  localparam int LW            = idx_width(P);
  localparam int TW            = idx_width(ROWS_PER_LANE);

  localparam logic [CW-1:0] COL_LAST  = CW'(K - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);
  localparam logic [TW-1:0] PASS_LAST = TW'(ROWS_PER_LANE - 1);

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [LW-1:0] lane_cnt;   // lane being written (LOAD_A) or emitted (EMIT)
  logic [TW-1:0] pass_cnt;   // row-within-lane (LOAD_A) or pass index t (COMPUTE..EMIT)
  logic          flush_cnt;
  logic          rd_v1, rd_v2;

  logic signed [B-1:0]     x_mem [K];
  logic signed [B-1:0]     x_q;
  logic signed [ACC_W-1:0] lane_res [P];
  logic [AW-1:0]           addr;
  logic                    rd_en, acc_clr, latch;

  // LOAD_A and COMPUTE share the same (row-within-lane, column) addressing.
  assign addr    = AW'(pass_cnt) * AW'(K) + AW'(col_cnt);
  assign rd_en   = (state == COMPUTE);
  assign acc_clr = rd_en && (col_cnt == '0);
  assign latch   = (state == FLUSH) && flush_cnt;

  always_ff @(posedge clk) begin
    if (state == LOAD_X && in_valid) x_mem[col_cnt] <= in_data;
  end

  // x read register and valid shadow of the two-stage lane pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= '0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
    end else begin
      x_q   <= x_mem[col_cnt];
      rd_v1 <= rd_en;
      rd_v2 <= rd_v1;
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    mvm_lane #(
      .B(B), .ACC_W(ACC_W), .A_DEPTH(A_DEPTH), .AW(AW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   ((state == LOAD_A) && in_valid && (lane_cnt == LW'(i))),
      .addr    (addr),
      .wr_data (in_data),
      .x_val   (x_q),
      .acc_clr (acc_clr),
      .acc_en  (rd_v2),
      .latch   (latch),
      .result  (lane_res[i])
    );
  end

  assign out_data = lane_res[lane_cnt];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      col_cnt   <= '0;
      lane_cnt  <= '0;
      pass_cnt  <= '0;
      flush_cnt <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          col_cnt  <= '0;
          lane_cnt <= '0;
          pass_cnt <= '0;
          if (load_matrix) begin
            state <= LOAD_A; in_ready <= 1'b1; busy <= 1'b1;
          end else if (load_vector) begin
            state <= LOAD_X; in_ready <= 1'b1; busy <= 1'b1;
          end else if (start) begin
            state <= COMPUTE; busy <= 1'b1;
          end
        end
        // Row-major beat n maps to lane r%P, row-within-lane r/P, column n%K.
        LOAD_A: if (in_valid) begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            if (lane_cnt == LANE_LAST) begin
              lane_cnt <= '0;
              if (pass_cnt == PASS_LAST) begin
                pass_cnt <= '0; state <= IDLE; in_ready <= 1'b0; busy <= 1'b0;
              end else begin
                pass_cnt <= pass_cnt + TW'(1);
              end
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
            end
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        LOAD_X: if (in_valid) begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0; state <= IDLE; in_ready <= 1'b0; busy <= 1'b0;
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        COMPUTE: begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0; flush_cnt <= 1'b0; state <= FLUSH;
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            state     <= EMIT;
            out_valid <= 1'b1;
            lane_cnt  <= '0;
            out_last  <= (P == 1) && (pass_cnt == PASS_LAST);
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        EMIT: if (out_ready) begin
          if (lane_cnt == LANE_LAST) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            lane_cnt  <= '0;
            if (pass_cnt == PASS_LAST) begin
              pass_cnt <= '0; done <= 1'b1; busy <= 1'b0; state <= IDLE;
            end else begin
              pass_cnt <= pass_cnt + TW'(1); state <= COMPUTE;
            end
          end else begin
            lane_cnt <= lane_cnt + LW'(1);
            out_last <= (lane_cnt + LW'(1) == LANE_LAST) && (pass_cnt == PASS_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream.sv
module tb_mvm_stream;

  typedef logic [15:0][7:0]  a_t;
  typedef logic [3:0][7:0]   x_t;
  typedef logic [3:0][17:0]  y_t;

  typedef struct {
    a_t a;
    x_t x;
    y_t y;
    int gap;
    int stall;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
  logic signed [7:0]  in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_last, busy, done;

  int checks = 0;
  int errors = 0;
  vec_t tv [5];

  mvm_stream #(.K(4), .M(4), .P(2), .B(8), .ACC_W(18)) dut (
    .clk(clk), .reset(reset),
    .load_matrix(load_matrix), .load_vector(load_vector), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic y_t mk_y(input int a, input int b, input int c, input int d);
    y_t y;
    y[0] = 18'(a); y[1] = 18'(b); y[2] = 18'(c); y[3] = 18'(d);
    return y;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load_a(input a_t a, input int gap);
    int n = 0, guard = 0;
    logic rdy;
    load_matrix = 1'b1; tick(); load_matrix = 1'b0;
    while (n < 16 && guard < 500) begin
      chk("in_ready_during_load_a", in_ready, 1);
      if (gap > 0 && $urandom_range(0, 99) < gap) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_data = a[n]; end
      rdy = in_ready;
      tick(); guard++;
      if (in_valid && rdy) n++;
    end
    in_valid = 1'b0;
    chk("load_a_beats", n, 16);
    chk("in_ready_after_load_a", in_ready, 0);
  endtask

  task automatic do_load_x(input x_t x, input int gap);
    int n = 0, guard = 0;
    logic rdy;
    load_vector = 1'b1; tick(); load_vector = 1'b0;
    while (n < 4 && guard < 200) begin
      chk("in_ready_during_load_x", in_ready, 1);
      if (gap > 0 && $urandom_range(0, 99) < gap) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_data = x[n]; end
      rdy = in_ready;
      tick(); guard++;
      if (in_valid && rdy) n++;
    end
    in_valid = 1'b0;
    chk("load_x_beats", n, 4);
    chk("in_ready_after_load_x", in_ready, 0);
  endtask

  task automatic collect(input y_t y, input int stall, input bit do_start);
    int g;
    out_ready = (stall == 0);
    if (do_start) begin start = 1'b1; tick(); start = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      g = 0;
      while (!out_valid && g < 200) begin tick(); g++; end
      if (!out_valid) begin
        checks++; errors++;
        $display("FAIL out_valid_timeout: beat %0d never arrived", i);
        out_ready = 1'b1;
        return;
      end
      if (i == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_valid_held", out_valid, 1);
          chk("stall_data_held", out_data, $signed(y[0]));
          chk("stall_last_low", out_last, 0);
          tick();
        end
        out_ready = 1'b1;
      end
      chk($sformatf("out_data[%0d]", i), out_data, $signed(y[i]));
      chk($sformatf("out_last[%0d]", i), out_last, (i == 3) ? 1 : 0);
      if (i < 3) chk("done_early", done, 0);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    // Vector table: A row-major, x, expected y in output order.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tv[0].a[r*4+c] = (r == c) ? 8'sd1 : 8'sd0;
        tv[1].a[r*4+c] = -8'sd128;
        tv[2].a[r*4+c] = 8'sd127;
        tv[3].a[r*4+c] = 8'(r + 1);
        tv[4].a[r*4+c] = 8'(r + 1);
      end
    for (int c = 0; c < 4; c++) begin
      tv[0].x[c] = 8'(c + 1);
      tv[1].x[c] = -8'sd128;
      tv[2].x[c] = -8'sd128;
      tv[3].x[c] = 8'sd1;
      tv[4].x[c] = 8'(c + 1);
    end
    tv[0].y = mk_y(1, 2, 3, 4);             tv[0].gap = 0;  tv[0].stall = 0;
    tv[1].y = mk_y(65536, 65536, 65536, 65536); tv[1].gap = 0; tv[1].stall = 0;
    tv[2].y = mk_y(-65024, -65024, -65024, -65024); tv[2].gap = 0; tv[2].stall = 0;
    tv[3].y = mk_y(4, 8, 12, 16);           tv[3].gap = 0;  tv[3].stall = 5;
    tv[4].y = mk_y(10, 20, 30, 40);         tv[4].gap = 50; tv[4].stall = 0;

    // Reset state.
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      do_load_a(tv[v].a, tv[v].gap);
      do_load_x(tv[v].x, tv[v].gap);
      collect(tv[v].y, tv[v].stall, 1'b1);
      repeat (2) tick();
    end

    // Commands during COMPUTE are ignored; A/x from the last vector stay in place.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    load_vector = 1'b1; start = 1'b1; tick();
    load_vector = 1'b0; start = 1'b0;
    chk("ignored_cmd_busy", busy, 1);
    chk("ignored_cmd_in_ready", in_ready, 0);
    collect(mk_y(10, 20, 30, 40), 0, 1'b0);

    // Reload x only; A persists.
    do_load_x(x_t'({8'sd2, 8'sd2, 8'sd2, 8'sd2}), 0);
    collect(mk_y(8, 16, 24, 32), 0, 1'b1);
    tick();

    // Reset during pass 1 COMPUTE.
    begin
      int g = 0;
      out_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      while (!out_valid && g < 200) begin tick(); g++; end
      chk("pre_reset_y0", out_data, 8);
      tick();
      chk("pre_reset_y1", out_data, 16);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done, 0);
      @(posedge clk); #3 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("post_rst_no_done", done, 0);
        chk("post_rst_idle", busy, 0);
      end
    end
    collect(mk_y(8, 16, 24, 32), 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
